// File: rtl/lnvd_spkr_pkg.sv
// Shared definitions for the speaker DAC sequencer: sample and SPI word
// widths, the SPI word field positions, the frame FSM state encoding and a
// helper that packs one channel sample into its 16-bit DAC command word.
package lnvd_spkr_pkg;

   localparam int DATA_W   = 12;
   localparam int CH_COUNT = 4;
   localparam int WORD_W   = 16;

   // DAC command word layout: {ch_idx[1:0], reserved 0, active 1, data[11:0]}
   localparam int IDX_MSB    = 15;
   localparam int IDX_LSB    = 14;
   localparam int RSVD_BIT   = 13;
   localparam int ACTIVE_BIT = 12;
   localparam int DATA_MSB   = 11;

   localparam logic ACTIVE = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SHIFT,
      ST_GAP,
      ST_LATCH
   } state_t;

   // Pack a channel index and a 12-bit sample into one DAC command word.
   function automatic logic [WORD_W-1:0] build_word(input logic [1:0]        idx,
                                                    input logic [DATA_W-1:0] data);
      logic [WORD_W-1:0] w;
      w                   = '0;
      w[IDX_MSB:IDX_LSB]  = idx;
      w[RSVD_BIT]         = 1'b0;
      w[ACTIVE_BIT]       = ACTIVE;
      w[DATA_MSB:0]       = data;
      return w;
   endfunction

endpackage

// File: rtl/spkr_spi_shifter.sv
// SPI word shifter for the shared DAC. A start pulse loads a 16-bit word,
// drops cs_n and presents bit 15 on mosi. sclk then toggles every CLK_DIV
// clocks (starting and ending low); mosi advances only on sclk falling
// edges, so the DAC samples stable data on each rising edge. After the 16th
// falling edge cs_n rises and done pulses for one cycle.
//
// Ports:
//   clk, rst  - system clock, synchronous active-high reset
//   start     - one-cycle load/begin request (ignored while active)
//   word      - 16-bit word to send, MSB first
//   sclk      - registered serial clock
//   mosi      - registered serial data
//   cs_n      - registered active-low chip select
//   done      - high in the cycle whose clock edge ends the word
module spkr_spi_shifter #(
   parameter int CLK_DIV = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] word,
   output logic        sclk,
   output logic        mosi,
   output logic        cs_n,
   output logic        done
);
   import lnvd_spkr_pkg::*;

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [4:0] LAST_EDGE = 5'(2 * WORD_W - 1);

   logic              active_q, active_d;
   logic              cs_n_q, cs_n_d;
   logic              sclk_q, sclk_d;
   logic              mosi_q, mosi_d;
   logic [WORD_W-1:0] shreg_q, shreg_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [4:0]        edge_q, edge_d;

   // Divider counts clocks per sclk half-period; edge_q counts sclk
   // transitions (32 per word). Odd edges are falling edges, where the next
   // bit is presented, and the final falling edge also releases cs_n.
   always_comb begin
      active_d = active_q;
      cs_n_d   = cs_n_q;
      sclk_d   = sclk_q;
      mosi_d   = mosi_q;
      shreg_d  = shreg_q;
      div_d    = div_q;
      edge_d   = edge_q;
      done     = 1'b0;
      if (start && !active_q) begin
         active_d = 1'b1;
         cs_n_d   = 1'b0;
         sclk_d   = 1'b0;
         mosi_d   = word[WORD_W-1];
         shreg_d  = {word[WORD_W-2:0], 1'b0};
         div_d    = '0;
         edge_d   = '0;
      end else if (active_q) begin
         if (div_q == DIV_LAST) begin
            div_d  = '0;
            sclk_d = ~sclk_q;
            edge_d = edge_q + 5'd1;
            if (sclk_q) begin
               if (edge_q == LAST_EDGE) begin
                  active_d = 1'b0;
                  cs_n_d   = 1'b1;
                  mosi_d   = 1'b0;
                  done     = 1'b1;
               end else begin
                  mosi_d  = shreg_q[WORD_W-1];
                  shreg_d = {shreg_q[WORD_W-2:0], 1'b0};
               end
            end
         end else begin
            div_d = div_q + DIV_W'(1);
         end
      end
   end

   // State registers with synchronous reset to the idle pin levels.
   always_ff @(posedge clk) begin
      if (rst) begin
         active_q <= 1'b0;
         cs_n_q   <= 1'b1;
         sclk_q   <= 1'b0;
         mosi_q   <= 1'b0;
         shreg_q  <= '0;
         div_q    <= '0;
         edge_q   <= '0;
      end else begin
         active_q <= active_d;
         cs_n_q   <= cs_n_d;
         sclk_q   <= sclk_d;
         mosi_q   <= mosi_d;
         shreg_q  <= shreg_d;
         div_q    <= div_d;
         edge_q   <= edge_d;
      end
   end

   assign sclk = sclk_q;
   assign mosi = mosi_q;
   assign cs_n = cs_n_q;

endmodule

// File: rtl/spkr_dac_sequencer.sv
// Speaker DAC frame sequencer. On a sample tick in IDLE all four channel
// samples are snapshotted (each optionally mirrored to 4095 - x), then four
// 16-bit command words are sent A..D over the shared SPI shifter, and LDAC
// is pulsed low for two cycles so all DAC outputs update together.
//
// Ports:
//   clk, rst             - system clock, synchronous active-high reset
//   sample_tick          - one-cycle frame request
//   ch_a..ch_d           - 12-bit channel samples
//   invert_en[3:0]       - per-channel mirror enable (bit0 = A)
//   busy                 - high while a frame is in progress
//   frame_done           - one-cycle pulse on return to IDLE
//   overrun              - sticky: tick arrived while busy (cleared by rst)
//   dac_cs_n, dac_sclk,
//   dac_mosi, dac_ldac_n - registered DAC pins
module spkr_dac_sequencer #(
   parameter int CLK_DIV = 1,
   parameter int DATA_W  = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sample_tick,
   input  logic [DATA_W-1:0] ch_a,
   input  logic [DATA_W-1:0] ch_b,
   input  logic [DATA_W-1:0] ch_c,
   input  logic [DATA_W-1:0] ch_d,
   input  logic [3:0]        invert_en,
   output logic              busy,
   output logic              frame_done,
   output logic              overrun,
   output logic              dac_cs_n,
   output logic              dac_sclk,
   output logic              dac_mosi,
   output logic              dac_ldac_n
);
   import lnvd_spkr_pkg::*;

   state_t            state_q, state_d;
   logic [1:0]        ch_idx_q, ch_idx_d;
   logic              latch_cnt_q, latch_cnt_d;
   logic              busy_q, busy_d;
   logic              frame_done_q, frame_done_d;
   logic              overrun_q, overrun_d;
   logic              ldac_n_q, ldac_n_d;
   logic [DATA_W-1:0] snap_q [CH_COUNT];
   logic [DATA_W-1:0] snap_d [CH_COUNT];
   logic [DATA_W-1:0] ch_in  [CH_COUNT];

   logic              shift_start;
   logic              shift_done;
   logic [WORD_W-1:0] shift_word;

   always_comb begin
      ch_in[0] = ch_a;
      ch_in[1] = ch_b;
      ch_in[2] = ch_c;
      ch_in[3] = ch_d;
   end

   assign shift_word = build_word(ch_idx_q, snap_q[ch_idx_q]);

   // Frame FSM. The mirror is applied while snapshotting, so later input or
   // invert_en changes cannot disturb a frame in flight. Registered outputs
   // are derived from the next state so they line up with the state change.
   always_comb begin
      state_d      = state_q;
      ch_idx_d     = ch_idx_q;
      latch_cnt_d  = latch_cnt_q;
      snap_d       = snap_q;
      shift_start  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (sample_tick) begin
               state_d  = ST_LOAD;
               ch_idx_d = 2'd0;
               for (int i = 0; i < CH_COUNT; i++) begin
                  snap_d[i] = invert_en[i] ? ~ch_in[i] : ch_in[i];
               end
            end
         end
         ST_LOAD: begin
            shift_start = 1'b1;
            state_d     = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (shift_done) begin
               state_d = ST_GAP;
            end
         end
         ST_GAP: begin
            if (ch_idx_q == 2'd3) begin
               state_d     = ST_LATCH;
               latch_cnt_d = 1'b0;
            end else begin
               ch_idx_d = ch_idx_q + 2'd1;
               state_d  = ST_LOAD;
            end
         end
         ST_LATCH: begin
            if (latch_cnt_q) begin
               state_d = ST_IDLE;
            end else begin
               latch_cnt_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      overrun_d    = overrun_q | (sample_tick && (state_q != ST_IDLE));
      busy_d       = (state_d != ST_IDLE);
      frame_done_d = (state_q == ST_LATCH) && (state_d == ST_IDLE);
      ldac_n_d     = (state_d != ST_LATCH);
   end

   // All sequencer state and registered outputs; reset abandons any frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         ch_idx_q     <= 2'd0;
         latch_cnt_q  <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         overrun_q    <= 1'b0;
         ldac_n_q     <= 1'b1;
         snap_q       <= '{default: '0};
      end else begin
         state_q      <= state_d;
         ch_idx_q     <= ch_idx_d;
         latch_cnt_q  <= latch_cnt_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
         overrun_q    <= overrun_d;
         ldac_n_q     <= ldac_n_d;
         snap_q       <= snap_d;
      end
   end

   spkr_spi_shifter #(
      .CLK_DIV (CLK_DIV)
   ) u_shifter (
      .clk   (clk),
      .rst   (rst),
      .start (shift_start),
      .word  (shift_word),
      .sclk  (dac_sclk),
      .mosi  (dac_mosi),
      .cs_n  (dac_cs_n),
      .done  (shift_done)
   );

   assign busy       = busy_q;
   assign frame_done = frame_done_q;
   assign overrun    = overrun_q;
   assign dac_ldac_n = ldac_n_q;

endmodule

// File: tb/tb_spkr_dac_sequencer.sv
// Bench for spkr_dac_sequencer. Two instances (CLK_DIV = 1 and 3) share all
// inputs. A frame-schedule model predicts every pin from the tick edge and
// the snapshotted words; a compare process checks both instances each cycle.
// Directed frames are also decoded off the pins and pinned to literal words
// and edge numbers.
module tb_spkr_dac_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        sample_tick;
   logic [11:0] ch_a, ch_b, ch_c, ch_d;
   logic [3:0]  invert_en;

   logic        busy0, fd0, ovr0, cs0, sclk0, mosi0, ldac0;
   logic        busy1, fd1, ovr1, cs1, sclk1, mosi1, ldac1;

   // Pin vector per instance: {cs_n, sclk, mosi, ldac_n, busy, frame_done, overrun}
   logic [6:0]  pins [2];

   int          checks = 0;
   int          errors = 0;

   int          cyc = 0;
   bit          modelValid = 0;
   bit          mAct [2];
   int          mStart [2];
   logic [63:0] mWords [2];
   bit          mOvr [2];

   int          frameId = 0;
   int          seenId = 0;
   logic        prevSclk [2];
   logic [15:0] shiftAcc [2];
   int          bitCnt [2];
   logic [15:0] capWord [2][4];
   int          capCount [2];
   int          fdCount [2];
   int          fdCyc [2];
   int          ldacFirst [2];
   int          ldacLast [2];

   always #5 clk = ~clk;

   spkr_dac_sequencer #(.CLK_DIV(1), .DATA_W(12)) dut (
      .clk(clk), .rst(rst), .sample_tick(sample_tick),
      .ch_a(ch_a), .ch_b(ch_b), .ch_c(ch_c), .ch_d(ch_d), .invert_en(invert_en),
      .busy(busy0), .frame_done(fd0), .overrun(ovr0),
      .dac_cs_n(cs0), .dac_sclk(sclk0), .dac_mosi(mosi0), .dac_ldac_n(ldac0)
   );

   spkr_dac_sequencer #(.CLK_DIV(3), .DATA_W(12)) dut3 (
      .clk(clk), .rst(rst), .sample_tick(sample_tick),
      .ch_a(ch_a), .ch_b(ch_b), .ch_c(ch_c), .ch_d(ch_d), .invert_en(invert_en),
      .busy(busy1), .frame_done(fd1), .overrun(ovr1),
      .dac_cs_n(cs1), .dac_sclk(sclk1), .dac_mosi(mosi1), .dac_ldac_n(ldac1)
   );

   assign pins[0] = {cs0, sclk0, mosi0, ldac0, busy0, fd0, ovr0};
   assign pins[1] = {cs1, sclk1, mosi1, ldac1, busy1, fd1, ovr1};

   function automatic int dOf(input int i);
      return (i == 0) ? 1 : 3;
   endfunction

   // Four command words from the current inputs, word k in bits [16k +: 16].
   function automatic logic [63:0] snapshotWords();
      logic [63:0] wv;
      logic [11:0] c;
      logic [11:0] data;
      wv = '0;
      for (int k = 0; k < 4; k++) begin
         case (k)
            0:       c = ch_a;
            1:       c = ch_b;
            2:       c = ch_c;
            default: c = ch_d;
         endcase
         data = invert_en[k] ? (12'hFFF - c) : c;
         wv[16*k +: 16] = {2'(k), 1'b0, 1'b1, data};
      end
      return wv;
   endfunction

   // Pin levels o edges after the accepting edge of a frame with divider d.
   function automatic logic [5:0] expectPins(input int d, input bit act, input int o,
                                            input logic [63:0] wv);
      int          p, k, r, t;
      logic [15:0] w;
      logic        cs, sc, mo, ld, bz, fd;
      cs = 1'b1; sc = 1'b0; mo = 1'b0; ld = 1'b1; bz = 1'b0; fd = 1'b0;
      if (act && o >= 0) begin
         p = 32 * d + 2;
         if (o < 128 * d + 10) bz = 1'b1;
         if (o == 128 * d + 10) fd = 1'b1;
         if (o < 4 * p) begin
            k = o / p;
            r = o % p;
            if (r >= 1 && r <= 32 * d) begin
               t  = r - 1;
               w  = wv[16*k +: 16];
               cs = 1'b0;
               sc = ((t % (2 * d)) >= d);
               mo = w[15 - t / (2 * d)];
            end
         end else if (o < 128 * d + 10) begin
            ld = 1'b0;
         end
      end
      return {cs, sc, mo, ld, bz, fd};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Model update: frame acceptance, overrun and reset, judged from whether
   // the previous frame was still running just before this edge.
   always @(posedge clk) begin : modelProc
      int nc;
      int prevO;
      nc = cyc + 1;
      cyc <= nc;
      if (rst) begin
         modelValid <= 1'b1;
         for (int i = 0; i < 2; i++) begin
            mAct[i] <= 1'b0;
            mOvr[i] <= 1'b0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            prevO = nc - 1 - mStart[i];
            if (sample_tick) begin
               if (!mAct[i] || prevO >= 128 * dOf(i) + 10) begin
                  mAct[i]   <= 1'b1;
                  mStart[i] <= nc;
                  mWords[i] <= snapshotWords();
               end else begin
                  mOvr[i] <= 1'b1;
               end
            end
         end
      end
   end

   // Per-cycle comparison of both instances against the model.
   always @(negedge clk) begin : compareProc
      logic [6:0] expv;
      if (modelValid) begin
         for (int i = 0; i < 2; i++) begin
            expv = {expectPins(dOf(i), mAct[i], cyc - mStart[i], mWords[i]), mOvr[i]};
            checkOutput($sformatf("pins dut%0d edge %0d", i, cyc), {25'd0, pins[i]},
                        {25'd0, expv});
         end
      end
   end

   // Decode words off the pins (sample mosi when sclk has just risen) and
   // record frame_done / ldac_n timing; cleared whenever frameId changes.
   always @(negedge clk) begin : captureProc
      logic [15:0] acc;
      if (frameId != seenId) begin
         seenId <= frameId;
         for (int i = 0; i < 2; i++) begin
            bitCnt[i]    <= 0;
            capCount[i]  <= 0;
            fdCount[i]   <= 0;
            fdCyc[i]     <= -1;
            ldacFirst[i] <= -1;
            ldacLast[i]  <= -1;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (pins[i][6]) begin
               bitCnt[i] <= 0;
            end else if (pins[i][5] && !prevSclk[i]) begin
               acc = {shiftAcc[i][14:0], pins[i][4]};
               shiftAcc[i] <= acc;
               if (bitCnt[i] == 15) begin
                  bitCnt[i] <= 0;
                  if (capCount[i] < 4) capWord[i][capCount[i]] <= acc;
                  capCount[i] <= capCount[i] + 1;
               end else begin
                  bitCnt[i] <= bitCnt[i] + 1;
               end
            end
            if (pins[i][1]) begin
               fdCount[i] <= fdCount[i] + 1;
               if (fdCount[i] == 0) fdCyc[i] <= cyc;
            end
            if (!pins[i][3]) begin
               if (ldacFirst[i] < 0) ldacFirst[i] <= cyc;
               ldacLast[i] <= cyc;
            end
         end
      end
      for (int i = 0; i < 2; i++) prevSclk[i] <= pins[i][5];
   end

   task automatic runCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Hold tick/rst for one edge; edgeNo is the edge that samples them.
   task automatic applyStimulus(input bit doTick, input bit doRst, output int edgeNo);
      sample_tick = doTick;
      rst         = doRst;
      edgeNo      = cyc + 1;
      @(negedge clk);
      sample_tick = 1'b0;
      rst         = 1'b0;
   endtask

   initial begin : mainProc
      int  tA, tB, tC, tD, tmp;
      bit  seen;
      rst         = 1'b1;
      sample_tick = 1'b0;
      ch_a = 12'h000; ch_b = 12'h000; ch_c = 12'h000; ch_d = 12'h000;
      invert_en   = 4'b0000;
      runCycles(3);

      checkOutput("reset cs_n", cs0, 1);
      checkOutput("reset sclk", sclk0, 0);
      checkOutput("reset mosi", mosi0, 0);
      checkOutput("reset ldac_n", ldac0, 1);
      checkOutput("reset busy", busy0, 0);
      checkOutput("reset frame_done", fd0, 0);
      checkOutput("reset overrun", ovr0, 0);
      checkOutput("reset pins dut3", {25'd0, pins[1]}, 32'h48);
      rst = 1'b0;
      runCycles(1);

      // Frame A: plain words, ch_b changed after snapshot, extra tick at +60
      ch_a = 12'h000; ch_b = 12'hFFF; ch_c = 12'h0C8; ch_d = 12'hBB8;
      invert_en = 4'b0000;
      frameId++;
      applyStimulus(1'b1, 1'b0, tA);
      runCycles(4);
      ch_b = 12'h123;
      runCycles(55);
      applyStimulus(1'b1, 1'b0, tmp);
      checkOutput("overrun tick edge", tmp - tA, 60);
      runCycles(340);
      checkOutput("A word count", capCount[0], 4);
      checkOutput("A word0", capWord[0][0], 32'h1000);
      checkOutput("A word1 snapshot", capWord[0][1], 32'h5FFF);
      checkOutput("A word2", capWord[0][2], 32'h90C8);
      checkOutput("A word3", capWord[0][3], 32'hDBB8);
      checkOutput("A frame_done edge", fdCyc[0] - tA, 138);
      checkOutput("A frame_done pulses", fdCount[0], 1);
      checkOutput("A ldac first edge", ldacFirst[0] - tA, 136);
      checkOutput("A ldac last edge", ldacLast[0] - tA, 137);
      checkOutput("A overrun sticky", ovr0, 1);
      checkOutput("A div3 word1", capWord[1][1], 32'h5FFF);
      checkOutput("A div3 word3", capWord[1][3], 32'hDBB8);
      checkOutput("A div3 frame_done edge", fdCyc[1] - tA, 394);
      checkOutput("A div3 ldac first edge", ldacFirst[1] - tA, 392);
      checkOutput("A div3 overrun", ovr1, 1);

      // Frame B: all channels mirrored, then a tick in the frame_done cycle
      ch_b = 12'hFFF;
      invert_en = 4'b1111;
      frameId++;
      applyStimulus(1'b1, 1'b0, tB);
      seen = 1'b0;
      for (int n = 0; n < 300 && !seen; n++) begin
         @(negedge clk);
         if (fd0) seen = 1'b1;
      end
      checkOutput("B frame_done seen", seen, 1);
      checkOutput("B frame_done edge", cyc - tB, 138);
      checkOutput("B word0", capWord[0][0], 32'h1FFF);
      checkOutput("B word1", capWord[0][1], 32'h5000);
      checkOutput("B word2", capWord[0][2], 32'h9F37);
      checkOutput("B word3", capWord[0][3], 32'hD447);
      invert_en = 4'b0000;
      frameId++;
      applyStimulus(1'b1, 1'b0, tC);
      checkOutput("C accept edge", tC - tB, 139);
      checkOutput("C busy after accept", busy0, 1);

      // Reset at edge 50 of frame C
      runCycles(49);
      applyStimulus(1'b0, 1'b1, tmp);
      checkOutput("rst edge", tmp - tC, 50);
      checkOutput("rst cs_n", cs0, 1);
      checkOutput("rst sclk", sclk0, 0);
      checkOutput("rst busy", busy0, 0);
      checkOutput("rst overrun", ovr0, 0);
      checkOutput("rst div3 overrun", ovr1, 0);

      // Frame D: mixed mirroring after reset
      runCycles(2);
      ch_a = 12'h5A5; ch_b = 12'h0A0; ch_c = 12'hFFF; ch_d = 12'h001;
      invert_en = 4'b0101;
      frameId++;
      applyStimulus(1'b1, 1'b0, tD);
      runCycles(400);
      checkOutput("D word0", capWord[0][0], 32'h1A5A);
      checkOutput("D word1", capWord[0][1], 32'h50A0);
      checkOutput("D word2", capWord[0][2], 32'h9000);
      checkOutput("D word3", capWord[0][3], 32'hD001);
      checkOutput("D frame_done edge", fdCyc[0] - tD, 138);
      checkOutput("D div3 word0", capWord[1][0], 32'h1A5A);
      checkOutput("D div3 word2", capWord[1][2], 32'h9000);
      checkOutput("D div3 frame_done edge", fdCyc[1] - tD, 394);
      checkOutput("D div3 frame_done pulses", fdCount[1], 1);
      checkOutput("D overrun clear", ovr0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/spkr_dac_sequencer.md
# spkr_dac_sequencer

Schedules the four 12-bit speaker channel samples onto one shared 4-channel serial DAC. On each sample tick it snapshots all four channels and optionally mirrors each one (4095 − x). It then shifts four 16-bit SPI words out in channel order A→D and pulses LDAC so all four outputs update together. It sits between the speaker inversion datapath and the DAC pins.

## Interface
- CLK_DIV, default 1: SCLK half-period in clk cycles; legal range ≥1.
- DATA_W, default 12: sample width; fixed at 12 for this DAC.
- clk  in  1  system clock (250 kHz).
- rst  in  1  synchronous, active-high reset.
- sample_tick  in  1  one-cycle request to start a frame.
- ch_a, ch_b, ch_c, ch_d  in  12 each  channel samples.
- invert_en  in  4  per-channel mirror enable; bit0 = A … bit3 = D.
- busy  out  1  high whenever the state is not IDLE.
- frame_done  out  1  one-cycle pulse when a frame completes.
- overrun  out  1  sticky flag: a tick arrived while busy.
- dac_cs_n, dac_sclk, dac_mosi, dac_ldac_n  out  1 each  DAC serial pins.

## Operation
- States and transitions:
  - IDLE→LOAD when sample_tick is high.
  - LOAD→SHIFT.
  - SHIFT→GAP after 16 SCLK periods.
  - GAP→LOAD if ch_idx < 3 (and ch_idx increments).
  - GAP→LATCH if ch_idx = 3.
  - LATCH→IDLE after 2 cycles.
- Snapshot: the IDLE→LOAD edge registers all four channels. Mirrored value = ~x, i.e. 12'hFFF − x. Input changes after the snapshot do not affect the frame.
- Word format: [15:14] = ch_idx, [13] = 0, [12] = 1 (active), [11:0] = data.
- SHIFT:
  - cs_n is low for the whole state; bits go out MSB first.
  - mosi changes only while sclk is low; the DAC samples on the sclk rising edge.
  - sclk toggles every CLK_DIV cycles, starting low and ending low.
- GAP: cs_n high and sclk low for exactly 1 cycle.
- LATCH: ldac_n low for both LATCH cycles.
- Overrun: a sample_tick in any non-IDLE state sets overrun and is otherwise ignored. The current frame is unaffected. Only rst clears overrun.
- A tick in the same cycle frame_done is high is accepted, since the state is already IDLE.
- rst mid-frame: on the next edge the block returns to IDLE and all outputs take their reset values. The partial word is abandoned; the DAC discards it because cs_n rises before 16 bits.

## Timing
- Reset values: cs_n = 1, sclk = 0, mosi = 0, ldac_n = 1, busy = 0, frame_done = 0, overrun = 0.
- Let edge 0 be the clock edge that samples sample_tick in IDLE; D = CLK_DIV.
  - Channel k LOAD starts at edge k·(32D+2).
  - cs_n falls at edge k·(32D+2)+1, with mosi = bit15 valid from that same edge.
  - cs_n rises at edge k·(32D+2)+1+32D.
  - LATCH is entered at edge 128D+8.
  - IDLE is entered at edge 128D+10, with frame_done high for that one cycle.
- busy is high from edge 0 until edge 128D+10.
- Minimum tick spacing is 128D+10 cycles: 138 cycles at D = 1 (about 1.81 kHz frame rate at 250 kHz).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package lnvd_spkr_pkg holds:
  - DATA_W, CH_COUNT = 4, WORD_W = 16;
  - word field bit positions and the ACTIVE bit constant;
  - the state encoding (IDLE, LOAD, SHIFT, GAP, LATCH).
- Sub-module spkr_spi_shifter takes a 16-bit word, a start pulse, and the CLK_DIV parameter. It produces sclk, mosi, cs_n and a done pulse, and owns the bit counter and the divider.
- The top level owns the FSM, the snapshot registers, the mirror logic, ch_idx, the latch counter and overrun.

## Test plan
- No-invert frame: D = 1, ch = 0x000/0xFFF/0x0C8/0xBB8, invert_en = 0, one tick → MOSI words 0x1000, 0x5FFF, 0x90C8, 0xDBB8. frame_done at edge 138; ldac_n low at edges 136–137.
- Mirrored frame: same inputs, invert_en = 4'b1111 → words 0x1FFF, 0x5000, 0x9F37, 0xD447.
- Snapshot isolation: change ch_b to 0x123 at edge 5 → the second word is still 0x5FFF.
- Overrun: a second tick at edge 60 → overrun = 1 and stays 1, exactly one frame_done pulse, no second frame. A tick at frame_done + 0 starts a new frame with LOAD at that edge.
- Reset mid-frame: assert rst at edge 50 → next edge gives cs_n = 1, sclk = 0, busy = 0, overrun = 0. A following tick produces a complete, correct frame.
- Divider: D = 3 → SCLK period of 6 cycles, cs_n low for 96 cycles per word, frame_done at edge 394.
